uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo.sv | 208 ++++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a byte FIFO: 16x-oversampled baud timing, optional
// odd/even parity, one or two stop bits, framing settings captured per frame.
module uart_tx_fifo #(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD_RATE  = 9600,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [15:0]                   baud_div,
  input  logic [1:0]                    parity_cfg,
  input  logic                          stop2,
  input  logic [7:0]                    s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  output logic                          tx,
  output logic                          tx_busy,
  output logic                          tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          fifo_empty,
  output logic                          fifo_full
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam int DEF_DIV_RAW = CLK_FREQ / BAUD_RATE / 16;
  localparam logic [15:0] DEF_DIV = (DEF_DIV_RAW < 1) ? 16'd1 : 16'(DEF_DIV_RAW);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic          push, pop;
  logic [7:0]    head_data;

  assign fifo_full  = (count_reg == FULL_CNT);
  assign fifo_empty = (count_reg == '0);
  assign s_ready    = !fifo_full;
  assign push       = s_valid && s_ready;
  assign head_data  = mem[rd_ptr_reg];
  assign fifo_count = count_reg;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= s_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  state_t      state_reg, state_next;
  logic [15:0] baud_cnt_reg, baud_cnt_next;
  logic [15:0] div_reg, div_next;
  logic [4:0]  tick_cnt_reg, tick_cnt_next;
  logic [2:0]  bit_idx_reg, bit_idx_next;
  logic [7:0]  shift_reg, shift_next;
  logic        par_bit_reg, par_bit_next;
  logic        par_en_reg, par_en_next;
  logic        stop2_lat_reg, stop2_lat_next;
  logic        tx_reg, tx_next;
  logic        done_reg, done_next;

  logic [15:0] eff_div;
  logic        tick;
  logic        bit_end;
  logic [4:0]  stop_last;

  // The divider is re-sampled on every counter wrap, so a new baud_div only
  // ever shortens or lengthens whole ticks.
  assign eff_div   = (baud_div != 16'd0) ? baud_div : DEF_DIV;
  assign tick      = (state_reg != IDLE) && (baud_cnt_reg == div_reg - 16'd1);
  assign bit_end   = tick && (tick_cnt_reg == 5'd15);
  assign stop_last = stop2_lat_reg ? 5'd31 : 5'd15;

  always_comb begin
    state_next     = state_reg;
    baud_cnt_next  = baud_cnt_reg;
    div_next       = div_reg;
    tick_cnt_next  = tick_cnt_reg;
    bit_idx_next   = bit_idx_reg;
    shift_next     = shift_reg;
    par_bit_next   = par_bit_reg;
    par_en_next    = par_en_reg;
    stop2_lat_next = stop2_lat_reg;
    tx_next        = tx_reg;
    done_next      = 1'b0;
    pop            = 1'b0;

    if (state_reg != IDLE) begin
      if (tick) begin
        baud_cnt_next = 16'd0;
        div_next      = eff_div;
        tick_cnt_next = tick_cnt_reg + 5'd1;
      end else begin
        baud_cnt_next = baud_cnt_reg + 16'd1;
      end
    end

    case (state_reg)
      IDLE: begin
        tx_next = 1'b1;
        if (!fifo_empty) begin
          pop            = 1'b1;
          shift_next     = head_data;
          par_en_next    = (parity_cfg == 2'd1) || (parity_cfg == 2'd2);
          par_bit_next   = (parity_cfg == 2'd1) ? ~^head_data : ^head_data;
          stop2_lat_next = stop2;
          tx_next        = 1'b0;
          baud_cnt_next  = 16'd0;
          div_next       = eff_div;
          tick_cnt_next  = 5'd0;
          bit_idx_next   = 3'd0;
          state_next     = START;
        end
      end
      START: begin
        if (bit_end) begin
          tick_cnt_next = 5'd0;
          tx_next       = shift_reg[0];
          state_next    = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          tick_cnt_next = 5'd0;
          if (bit_idx_reg == 3'd7) begin
            if (par_en_reg) begin
              tx_next    = par_bit_reg;
              state_next = PARITY;
            end else begin
              tx_next    = 1'b1;
              state_next = STOP;
            end
          end else begin
            bit_idx_next = bit_idx_reg + 3'd1;
            shift_next   = shift_reg >> 1;
            tx_next      = shift_reg[1];
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          tick_cnt_next = 5'd0;
          tx_next       = 1'b1;
          state_next    = STOP;
        end
      end
      STOP: begin
        if (tick && (tick_cnt_reg == stop_last)) begin
          tick_cnt_next = 5'd0;
          tx_next       = 1'b1;
          done_next     = 1'b1;
          state_next    = IDLE;
        end
      end
      default: begin
        tx_next    = 1'b1;
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      baud_cnt_reg  <= 16'd0;
      div_reg       <= 16'd1;
      tick_cnt_reg  <= 5'd0;
      bit_idx_reg   <= 3'd0;
      shift_reg     <= 8'd0;
      par_bit_reg   <= 1'b0;
      par_en_reg    <= 1'b0;
      stop2_lat_reg <= 1'b0;
      tx_reg        <= 1'b1;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      baud_cnt_reg  <= baud_cnt_next;
      div_reg       <= div_next;
      tick_cnt_reg  <= tick_cnt_next;
      bit_idx_reg   <= bit_idx_next;
      shift_reg     <= shift_next;
      par_bit_reg   <= par_bit_next;
      par_en_reg    <= par_en_next;
      stop2_lat_reg <= stop2_lat_next;
      tx_reg        <= tx_next;
      done_reg      <= done_next;
    end
  end

  assign tx      = tx_reg;
  assign tx_busy = (state_reg != IDLE);
  assign tx_done = done_reg;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: queue/waveform reference model compared every cycle,
// plus hand-computed frame timing and bit-value checks.
module tb_uart_tx_fifo;

  localparam int DEPTH   = 16;
  localparam int CLKF    = 1536000;
  localparam int BAUD    = 48000;
  localparam int DEF_DIV = CLKF / BAUD / 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] baud_div;
  logic [1:0]  parity_cfg;
  logic        stop2;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_ready;
  logic        tx;
  logic        tx_busy;
  logic        tx_done;
  logic [4:0]  fifo_count;
  logic        fifo_empty;
  logic        fifo_full;

  uart_tx_fifo #(.CLK_FREQ(CLKF), .BAUD_RATE(BAUD), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .baud_div(baud_div), .parity_cfg(parity_cfg),
    .stop2(stop2), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .tx(tx), .tx_busy(tx_busy), .tx_done(tx_done), .fifo_count(fifo_count),
    .fifo_empty(fifo_empty), .fifo_full(fifo_full)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: FIFO as a queue, each frame expanded into per-clock levels.
  logic [7:0] m_q[$];
  bit         m_wave[$];
  bit         fbits[$];
  bit         m_inframe = 1'b0;
  bit         m_valid   = 1'b0;
  bit         e_tx = 1'b1, e_busy = 1'b0, e_done = 1'b0;

  always @(posedge clk) begin
    logic [7:0] b;
    int         d;
    bit         acc;
    cyc++;
    if (rst) begin
      m_q.delete();
      m_wave.delete();
      m_inframe = 1'b0;
      e_tx = 1'b1; e_busy = 1'b0; e_done = 1'b0;
    end else begin
      acc = s_valid && (m_q.size() < DEPTH);
      e_done = 1'b0;
      if (m_inframe) begin
        if (m_wave.size() > 0) begin
          e_tx = m_wave.pop_front(); e_busy = 1'b1;
        end else begin
          m_inframe = 1'b0; e_done = 1'b1; e_busy = 1'b0; e_tx = 1'b1;
        end
      end else if (m_q.size() > 0) begin
        b = m_q.pop_front();
        d = (baud_div != 16'd0) ? int'(baud_div) : DEF_DIV;
        fbits.delete();
        fbits.push_back(1'b0);
        for (int i = 0; i < 8; i++) fbits.push_back(b[i]);
        if (parity_cfg == 2'd1) fbits.push_back(~^b);
        if (parity_cfg == 2'd2) fbits.push_back(^b);
        fbits.push_back(1'b1);
        if (stop2) fbits.push_back(1'b1);
        m_wave.delete();
        foreach (fbits[i]) for (int k = 0; k < 16 * d; k++) m_wave.push_back(fbits[i]);
        e_tx = m_wave.pop_front(); e_busy = 1'b1; m_inframe = 1'b1;
      end else begin
        e_tx = 1'b1; e_busy = 1'b0;
      end
      if (acc) m_q.push_back(s_data);
    end
    m_valid = 1'b1;
  end

  // Per-cycle compare plus frame start/done timestamps and tx history.
  int  starts[$];
  int  dones[$];
  int  last_start = 0;
  bit  prev_busy  = 1'b0;
  bit  hist [0:1023];

  always @(negedge clk) begin
    logic [10:0] got, exp_v;
    int          qs;
    if (m_valid) begin
      qs    = m_q.size();
      got   = {tx, tx_busy, tx_done, fifo_count, fifo_empty, fifo_full, s_ready};
      exp_v = {e_tx, e_busy, e_done, 5'(qs), qs == 0, qs == DEPTH, qs != DEPTH};
      checks++;
      if (got !== exp_v) begin
        errors++;
        $display("FAIL model_cmp cyc %0d got tx/busy/done=%b%b%b cnt=%0d e/f/r=%b%b%b exp tx/busy/done=%b%b%b cnt=%0d e/f/r=%b%b%b",
                 cyc, got[10], got[9], got[8], got[7:3], got[2], got[1], got[0],
                 exp_v[10], exp_v[9], exp_v[8], exp_v[7:3], exp_v[2], exp_v[1], exp_v[0]);
      end
      if (!prev_busy && tx_busy && !tx) begin
        last_start = cyc;
        starts.push_back(cyc);
      end
      if (cyc - last_start < 1024) hist[cyc - last_start] = tx;
      if (tx_done) dones.push_back(cyc);
      prev_busy = tx_busy;
    end
  end

  task automatic check(input string name, input int got, input int exp_v);
    checks++;
    if (got !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp_v);
    end else begin
      $display("check %s = %0d", name, got);
    end
  endtask

  task automatic push(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    s_valid = 1'b1; s_data = b;
    while (!s_ready && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) check("push_timeout", 1, 0);
    @(negedge clk);
    s_valid = 1'b0;
    $display("push 0x%02h", b);
  endtask

  task automatic wait_dones(input int n, input int budget);
    int k = 0;
    while (dones.size() < n && k < budget) begin @(negedge clk); k++; end
    if (dones.size() < n) check("done_timeout", dones.size(), n);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_start(input int budget);
    int k = 0;
    while (starts.size() < 1 && k < budget) begin @(negedge clk); k++; end
    if (starts.size() < 1) check("start_timeout", 0, 1);
  endtask

  task automatic clear_log();
    starts.delete();
    dones.delete();
  endtask

  function automatic int frame_len();
    if (starts.size() < 1 || dones.size() < 1) return -1;
    return dones[0] - starts[0];
  endfunction

  initial begin
    int  acc_n;
    bit  pend;
    int  k;
    rst = 1'b1; s_valid = 1'b0; s_data = 8'h00;
    baud_div = 16'd4; parity_cfg = 2'd0; stop2 = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_tx", tx, 1);
    check("reset_busy", tx_busy, 0);
    check("reset_count", fifo_count, 0);
    check("reset_ready", s_ready, 1);
    check("reset_empty", fifo_empty, 1);
    rst = 1'b0;

    // 0x55, divider 4, 8N1: 64 clocks per bit.
    clear_log();
    push(8'h55);
    wait_dones(1, 2000);
    check("f55_len", frame_len(), 640);
    check("f55_start", hist[32], 0);
    check("f55_bit0", hist[96], 1);
    check("f55_bit1", hist[160], 0);
    check("f55_stop", hist[620], 1);

    // Odd parity on 0x07; framing inputs changed mid-frame must not matter.
    baud_div = 16'd2; parity_cfg = 2'd1;
    clear_log();
    push(8'h07);
    repeat (3) @(negedge clk);
    parity_cfg = 2'd0; stop2 = 1'b1;
    wait_dones(1, 1000);
    check("odd_len", frame_len(), 352);
    check("odd_par", hist[300], 0);

    parity_cfg = 2'd2; stop2 = 1'b0;
    clear_log();
    push(8'h07);
    wait_dones(1, 1000);
    check("even_len", frame_len(), 352);
    check("even_par", hist[300], 1);

    // Back-to-back frames, even parity, two stop bits.
    stop2 = 1'b1;
    clear_log();
    push(8'hA3);
    push(8'h3C);
    wait_dones(2, 2000);
    check("b2b_len", frame_len(), 384);
    check("b2b_dones", dones.size(), 2);
    if (starts.size() >= 2) check("b2b_spacing", starts[1] - starts[0], 385);
    else check("b2b_starts", starts.size(), 2);

    // baud_div = 0 falls back to CLK_FREQ/BAUD_RATE/16 = 2.
    baud_div = 16'd0; parity_cfg = 2'd0; stop2 = 1'b0;
    clear_log();
    push(8'h81);
    wait_dones(1, 1000);
    check("defdiv_len", frame_len(), 320);

    // Stream 20 bytes with s_valid held: shifter + FIFO absorb 17.
    baud_div = 16'd100;
    clear_log();
    acc_n = 0;
    @(negedge clk);
    s_valid = 1'b1; s_data = 8'h05; pend = s_ready;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (pend) acc_n++;
      if (acc_n < 20) begin
        s_data = 8'(acc_n * 37 + 5);
        pend = s_ready;
      end else begin
        s_valid = 1'b0; pend = 1'b0;
      end
    end
    s_valid = 1'b0;
    check("fill_accepted", acc_n, 17);
    check("fill_full", fifo_full, 1);
    check("fill_ready", s_ready, 0);
    check("fill_count", fifo_count, 16);
    wait_dones(2, 34000);
    if (starts.size() >= 2) check("fill_spacing", starts[1] - starts[0], 16001);
    else check("fill_starts", starts.size(), 2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("fill_rst_count", fifo_count, 0);

    // Reset during data bit 3, then a clean frame.
    baud_div = 16'd2;
    clear_log();
    push(8'h5A);
    push(8'h11);
    wait_start(100);
    k = 0;
    while (starts.size() > 0 && (cyc - starts[0]) < 138 && k < 400) begin @(negedge clk); k++; end
    rst = 1'b1;
    @(negedge clk);
    check("abort_tx", tx, 1);
    check("abort_busy", tx_busy, 0);
    check("abort_count", fifo_count, 0);
    rst = 1'b0;
    clear_log();
    push(8'hF0);
    wait_dones(1, 1000);
    check("f0_len", frame_len(), 320);
    check("f0_bit0", hist[48], 0);
    check("f0_bit4", hist[176], 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
